// File: rtl/apb_master_if.sv
// apb_master_if: CPU request port and four-slave APB segment seen by apb_master.
interface apb_master_if;
   logic        transfer, write, ready;
   logic [31:0] addr, wdata, rdata;
   logic [31:0] PADDR, PWDATA;
   logic        PWRITE, PENABLE;
   logic        PSEL0, PSEL1, PSEL2, PSEL3;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
   logic        PREADY0, PREADY1, PREADY2, PREADY3;
   modport master (
      input  transfer, write, addr, wdata,
      input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY0, PREADY1, PREADY2, PREADY3,
      output rdata, ready, PADDR, PWDATA, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3
   );
   modport slave (
      output transfer, write, addr, wdata,
      output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY0, PREADY1, PREADY2, PREADY3,
      input  rdata, ready, PADDR, PWDATA, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding CPU-to-APB bridge with 4-slave address decode,
// unmapped-address completion and an ACCESS-phase timeout.
module apb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          TIMEOUT   = 16
) (
   input logic          PCLK,
   input logic          PRESET,
   apb_master_if.master bus
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t        state_q, state_d;
   logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d, prdata;
   logic          pwrite_q, pwrite_d, penable_q, penable_d;
   logic [3:0]    psel_q, psel_d, pready, dec;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [19:0]   off;
   logic          hit, done, accept;
   always_comb begin
      off       = bus.addr[31:12] - BASE_ADDR[31:12];
      dec       = (off < 20'd4) ? 4'b0001 << off[1:0] : 4'b0000;
      pready    = {bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0};
      prdata    = psel_q[0] ? bus.PRDATA0 : psel_q[1] ? bus.PRDATA1 :
                  psel_q[2] ? bus.PRDATA2 : bus.PRDATA3;
      hit       = |(psel_q & pready);
      // an empty select means unmapped, which completes on the first ACCESS cycle
      done      = state_q == ACCESS && (hit || psel_q == 4'b0000 || cnt_q == CW'(TIMEOUT - 1));
      accept    = bus.transfer && (state_q == IDLE || done);
      state_d   = accept ? SETUP :
                  (state_q == SETUP || (state_q == ACCESS && !done)) ? ACCESS : IDLE;
      paddr_d   = accept ? bus.addr : paddr_q;
      pwdata_d  = accept ? bus.wdata : pwdata_q;
      pwrite_d  = accept ? bus.write : pwrite_q;
      psel_d    = accept ? dec : state_d == IDLE ? 4'b0000 : psel_q;
      penable_d = state_d == ACCESS;
      cnt_d     = (state_q == ACCESS && !done) ? cnt_q + 1'b1 : '0;
   end
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 4'b0000;
         penable_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         cnt_q     <= cnt_d;
      end
   end
   assign bus.ready   = done;
   assign bus.rdata   = !done || psel_q == 4'b0000 ? 32'h0000_0000 : hit ? prdata : 32'hFFFF_FFFF;
   assign bus.PADDR   = paddr_q;
   assign bus.PWDATA  = pwdata_q;
   assign bus.PWRITE  = pwrite_q;
   assign bus.PENABLE = penable_q;
   assign bus.PSEL0   = psel_q[0];
   assign bus.PSEL1   = psel_q[1];
   assign bus.PSEL2   = psel_q[2];
   assign bus.PSEL3   = psel_q[3];
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed cycle-by-cycle vectors against hand-computed APB timing.
module tb_apb_master;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0, errs = 0, rdy_n = 0;
   logic [3:0] psel;
   always #5 clk = ~clk;
   apb_master_if bus();
   apb_master #(.BASE_ADDR(32'h1000_0000), .TIMEOUT(16)) dut (
      .PCLK(clk), .PRESET(rst), .bus(bus.master)
   );
   assign psel = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic mid();
      @(negedge clk);
   endtask
   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.transfer = 1'b1;
      bus.write    = w;
      bus.addr     = a;
      bus.wdata    = d;
   endtask
   task automatic quiet();
      bus.transfer = 1'b0;
      {bus.PREADY0, bus.PREADY1, bus.PREADY2, bus.PREADY3} = 4'b0000;
   endtask
   initial begin
      quiet();
      bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
      bus.PRDATA0 = '0; bus.PRDATA1 = '0; bus.PRDATA2 = '0; bus.PRDATA3 = '0;
      #2;
      chk("rst_psel", psel, 0);
      chk("rst_penable", bus.PENABLE, 0);
      chk("rst_ready", bus.ready, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_paddr", bus.PADDR, 0);
      chk("rst_pwdata", bus.PWDATA, 0);
      chk("rst_pwrite", bus.PWRITE, 0);
      #10 rst = 1'b0;
      tick();
      // write to slave 1, registered PREADY one cycle after PENABLE
      req(1'b1, 32'h1000_1004, 32'h0000_04D2);
      mid(); chk("t1_c0_psel", psel, 0); chk("t1_c0_ready", bus.ready, 0); tick();
      req(1'b1, 32'h1000_2FFC, 32'h0000_5555);
      mid();
      chk("t1_c1_psel", psel, 4'b0010); chk("t1_c1_penable", bus.PENABLE, 0);
      chk("t1_c1_paddr", bus.PADDR, 32'h1000_1004); chk("t1_c1_pwdata", bus.PWDATA, 32'h4D2);
      chk("t1_c1_pwrite", bus.PWRITE, 1); chk("t1_c1_ready", bus.ready, 0);
      tick();
      mid();
      chk("t1_c2_psel", psel, 4'b0010); chk("t1_c2_penable", bus.PENABLE, 1);
      chk("t1_c2_ready", bus.ready, 0); chk("t1_c2_paddr", bus.PADDR, 32'h1000_1004);
      tick();
      bus.transfer = 1'b0; bus.PREADY1 = 1'b1;
      mid();
      chk("t1_c3_ready", bus.ready, 1); chk("t1_c3_psel", psel, 4'b0010);
      chk("t1_c3_penable", bus.PENABLE, 1); chk("t1_c3_paddr", bus.PADDR, 32'h1000_1004);
      chk("t1_c3_pwdata", bus.PWDATA, 32'h4D2);
      tick();
      mid();
      chk("t1_c4_ready", bus.ready, 0); chk("t1_c4_psel", psel, 0);
      chk("t1_c4_penable", bus.PENABLE, 0); chk("t1_c4_paddr_hold", bus.PADDR, 32'h1000_1004);
      tick();
      quiet();
      // read from slave 2, PREADY2 late; early PREADY2 in SETUP and unselected PREADY1 ignored
      req(1'b0, 32'h1000_2008, 32'h0);
      bus.PRDATA2 = 32'h0000_000A; bus.PRDATA1 = 32'h1111_1111; bus.PREADY1 = 1'b1;
      mid(); tick();
      bus.PREADY2 = 1'b1;
      mid(); chk("t2_setup_psel", psel, 4'b0100); chk("t2_setup_ready", bus.ready, 0); tick();
      bus.PREADY2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid(); chk("t2_wait_ready", bus.ready, 0); chk("t2_wait_penable", bus.PENABLE, 1); tick();
      end
      bus.transfer = 1'b0; bus.PREADY2 = 1'b1;
      mid(); chk("t2_done_ready", bus.ready, 1); chk("t2_done_rdata", bus.rdata, 32'h0000_000A); tick();
      mid(); chk("t2_after_ready", bus.ready, 0); chk("t2_after_psel", psel, 0); tick();
      quiet();
      // back-to-back write slave 0 then read slave 3
      req(1'b1, 32'h1000_0000, 32'hA5A5_A5A5);
      mid(); rdy_n += int'(bus.ready); tick();
      mid(); chk("t3_c1_psel", psel, 4'b0001); rdy_n += int'(bus.ready); tick();
      bus.PREADY0 = 1'b1; req(1'b0, 32'h1000_3000, 32'h0);
      mid(); chk("t3_c2_ready", bus.ready, 1); chk("t3_c2_psel", psel, 4'b0001);
      rdy_n += int'(bus.ready); tick();
      bus.transfer = 1'b0;
      mid();
      chk("t3_c3_psel", psel, 4'b1000); chk("t3_c3_penable", bus.PENABLE, 0);
      chk("t3_c3_paddr", bus.PADDR, 32'h1000_3000); chk("t3_c3_pwrite", bus.PWRITE, 0);
      chk("t3_c3_ready", bus.ready, 0); rdy_n += int'(bus.ready);
      tick();
      bus.PREADY0 = 1'b0; bus.PREADY3 = 1'b1; bus.PRDATA3 = 32'h1234_5678;
      mid(); chk("t3_c4_ready", bus.ready, 1); chk("t3_c4_rdata", bus.rdata, 32'h1234_5678);
      chk("t3_c4_psel", psel, 4'b1000); rdy_n += int'(bus.ready); tick();
      bus.PREADY3 = 1'b0;
      mid(); chk("t3_c5_psel", psel, 0); rdy_n += int'(bus.ready);
      chk("t3_ready_count", rdy_n, 2); tick();
      quiet();
      // unmapped read
      req(1'b0, 32'h2000_0000, 32'h0); bus.PRDATA0 = 32'hDEAD_BEEF;
      mid(); tick();
      bus.transfer = 1'b0;
      mid(); chk("t4_c1_psel", psel, 0); chk("t4_c1_ready", bus.ready, 0); tick();
      mid(); chk("t4_c2_ready", bus.ready, 1); chk("t4_c2_rdata", bus.rdata, 0);
      chk("t4_c2_penable", bus.PENABLE, 1); chk("t4_c2_psel", psel, 0); tick();
      mid(); chk("t4_c3_ready", bus.ready, 0); chk("t4_c3_penable", bus.PENABLE, 0); tick();
      // timeout on slave 0
      req(1'b0, 32'h1000_0000, 32'h0); bus.PRDATA0 = 32'h0000_0077;
      mid(); tick();
      bus.transfer = 1'b0;
      mid(); chk("t5_setup_psel", psel, 4'b0001); tick();
      for (int i = 0; i < 15; i++) begin
         mid(); chk("t5_wait_ready", bus.ready, 0); tick();
      end
      mid(); chk("t5_to_ready", bus.ready, 1); chk("t5_to_rdata", bus.rdata, 32'hFFFF_FFFF); tick();
      mid(); chk("t5_idle_psel", psel, 0); chk("t5_idle_penable", bus.PENABLE, 0);
      chk("t5_idle_ready", bus.ready, 0); tick();
      // reset in the middle of ACCESS, then a clean read of slave 1
      req(1'b1, 32'h1000_2000, 32'h0000_0099);
      mid(); tick();
      bus.transfer = 1'b0;
      mid(); tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_psel", psel, 0); chk("t6_rst_penable", bus.PENABLE, 0);
      chk("t6_rst_ready", bus.ready, 0); chk("t6_rst_paddr", bus.PADDR, 0);
      chk("t6_rst_pwdata", bus.PWDATA, 0);
      mid(); tick();
      #3 rst = 1'b0;
      req(1'b0, 32'h1000_1000, 32'h0); bus.PREADY1 = 1'b1; bus.PRDATA1 = 32'hCAFE_F00D;
      mid(); chk("t6_c0_ready", bus.ready, 0); tick();
      bus.transfer = 1'b0;
      mid(); chk("t6_c1_psel", psel, 4'b0010); chk("t6_c1_ready", bus.ready, 0); tick();
      mid(); chk("t6_c2_ready", bus.ready, 1); chk("t6_c2_rdata", bus.rdata, 32'hCAFE_F00D); tick();
      quiet();
      mid(); chk("t6_c3_psel", psel, 0); chk("t6_c3_ready", bus.ready, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
